// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional macro MDU_FAST_MULT_EN: single-edge multiply through a full-width multiplier;
// without it, multiply uses the 32-iteration shift-add datapath shared with the divider.
module mult_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [PW-1:0]     p_q, p_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  // Operand decode, one shift-add / restoring step, and sign fix-up
  logic            op_signed, op_div, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_rem, div_diff;
  logic            div_ge;
  logic [PW-1:0]   mul_next, div_next, p_neg;
  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    a_neg     = op_signed & rs_data[XLEN-1];
    b_neg     = op_signed & rt_data[XLEN-1];
    a_mag     = a_neg ? (~rs_data + XLEN'(1)) : rs_data;
    b_mag     = b_neg ? (~rt_data + XLEN'(1)) : rt_data;

    mul_sum   = {1'b0, p_q[PW-1:XLEN]} + {1'b0, (p_q[0] ? b_q : XLEN'(0))};
    mul_next  = {mul_sum, p_q[XLEN-1:1]};

    div_rem   = {p_q[PW-1:XLEN], p_q[XLEN-1]};
    div_ge    = (div_rem >= {1'b0, b_q});
    div_diff  = div_rem - {1'b0, b_q};
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]), p_q[XLEN-2:0], div_ge};

    p_neg     = ~p_q + PW'(1);
    q_fix     = neg_res_q ? (~p_q[XLEN-1:0] + XLEN'(1)) : p_q[XLEN-1:0];
    r_fix     = neg_rem_q ? (~p_q[PW-1:XLEN] + XLEN'(1)) : p_q[PW-1:XLEN];
  end

`ifdef MDU_FAST_MULT_EN
  logic [PW-1:0] fast_mag, fast_prod;

  // Full-width magnitude product with sign applied for the single-edge multiply
  always_comb begin
    fast_mag  = PW'(a_mag) * PW'(b_mag);
    fast_prod = (a_neg ^ b_neg) ? (~fast_mag + PW'(1)) : fast_mag;
  end
`endif

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    p_d       = p_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == RUN) begin
      if (!last_q) begin
        p_d    = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        last_d = (cnt_q == {CNT_W{1'b1}});
      end else begin
        if (is_div_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end else begin
          {hi_d, lo_d} = neg_res_q ? p_neg : p_q;
        end
        last_d  = 1'b0;
        cnt_d   = '0;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
      if (start) begin
        is_div_d  = op_div;
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        p_d       = {XLEN'(0), a_mag};
        b_d       = b_mag;
        cnt_d     = '0;
        last_d    = 1'b0;
        if (op_div && (rt_data == XLEN'(0))) begin
          lo_d    = {XLEN{1'b1}};
          hi_d    = rs_data;
          state_d = DONE;
        end else begin
          state_d = RUN;
`ifdef MDU_FAST_MULT_EN
          if (!op_div) begin
            {hi_d, lo_d} = fast_prod;
            state_d      = DONE;
          end
`endif
        end
      end else begin
        if (mthi) hi_d = rs_data;
        if (mtlo) lo_d = rs_data;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      p_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      p_q       <= p_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  localparam int unsigned XLEN = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data, rt_data;
  logic            mthi, mtlo;
  logic            busy, done;
  logic [XLEN-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive a start with optional mt strobes through one edge; returns #1 after the start edge
  task automatic launch(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic mh, input logic ml);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mh; mtlo = ml;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // Count edges until done, bounded; reports whether HI/LO held steady while waiting
  task automatic wait_done(output int lat, output bit stable);
    logic [XLEN-1:0] h0, l0;
    h0 = hi; l0 = lo;
    lat = -1; stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i + 1;
        break;
      end
      if (hi !== h0 || lo !== l0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int lat; bit stable;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n_cmp++; if (busy !== (MUL_LAT != 1)) begin n_err++; $display("FAIL multu_busy got %b want %b", busy, (MUL_LAT != 1)); end
    wait_done(lat, stable);
    n_cmp++; if (lat != MUL_LAT) begin n_err++; $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL multu_hilo_stable got changed want steady"); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_done got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult();
    int lat; bit stable;
    launch(OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
    wait_done(lat, stable);
    n_cmp++; if (lat != MUL_LAT) begin n_err++; $display("FAIL mult_latency got %0d want %0d", lat, MUL_LAT); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
  endtask

  task automatic test_div();
    int lat; bit stable;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL div_busy got %b want 1", busy); end
    wait_done(lat, stable);
    n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL div_latency got %0d want %0d", lat, DIV_LAT); end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL div_hilo_stable got changed want steady"); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", hi); end
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(lat, stable);
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h want 00000002", hi); end
  endtask

  task automatic test_div_corner();
    int lat; bit stable;
    launch(OP_DIVU, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL div0_done got %b want 1", done); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL div0_hi got %h want 00001234", hi); end
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done(lat, stable);
    n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL divmin_latency got %0d want %0d", lat, DIV_LAT); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divmin_lo got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divmin_hi got %h want 00000000", hi); end
  endtask

  task automatic test_mt();
    int lat; bit stable;
    @(negedge clk);
    mthi = 1'b1; rs_data = 32'hAAAA_0000;
    @(posedge clk); #1; mthi = 1'b0;
    n_cmp++; if (hi !== 32'hAAAA_0000) begin n_err++; $display("FAIL mthi_hi got %h want aaaa0000", hi); end
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h5555_1111;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    n_cmp++; if (hi !== 32'h5555_1111) begin n_err++; $display("FAIL mtboth_hi got %h want 55551111", hi); end
    n_cmp++; if (lo !== 32'h5555_1111) begin n_err++; $display("FAIL mtboth_lo got %h want 55551111", lo); end
    // mtlo while running is ignored
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    mtlo = 1'b1; rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1; mtlo = 1'b0;
    n_cmp++; if (lo !== 32'h5555_1111) begin n_err++; $display("FAIL mtlo_run_lo got %h want 55551111", lo); end
    wait_done(lat, stable);
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL mtlo_run_result got %h want 0000000e", lo); end
    // start wins over a simultaneous mtlo
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL start_mtlo_lo got %h want 0000000e", lo); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_mtlo_busy got %b want 1", busy); end
    wait_done(lat, stable);
    n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL start_mtlo_latency got %0d want %0d", lat, DIV_LAT); end
  endtask

  task automatic test_back_to_back();
    int lat; bit stable;
    launch(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(lat, stable);
    // relaunch during the DONE cycle
    launch(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
    n_cmp++; if (done !== (MUL_LAT == 1)) begin n_err++; $display("FAIL b2b_done got %b want %b", done, (MUL_LAT == 1)); end
    if (MUL_LAT != 1) wait_done(lat, stable);
    n_cmp++; if (lo !== 32'd42) begin n_err++; $display("FAIL b2b_lo got %h want 0000002a", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_hi got %h want 00000000", hi); end
  endtask

  task automatic test_reset_mid();
    int lat; bit stable;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo got %h want 0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    launch(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);
    if (MUL_LAT == 1) lat = done ? 1 : -1;
    else wait_done(lat, stable);
    n_cmp++; if (lat != MUL_LAT) begin n_err++; $display("FAIL rstmid_mul_latency got %0d want %0d", lat, MUL_LAT); end
    n_cmp++; if (lo !== 32'd15) begin n_err++; $display("FAIL rstmid_mul_lo got %h want 0000000f", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL rstmid_mul_hi got %h want 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_corner();
    test_mt();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
